// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup and resolve-update bundle shared by the branch target buffer
// and its caller; master is the pipeline side, slave is the buffer.
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_is_jump;
  logic              flush;

  modport master (
    output fetch_pc, upd_en, upd_pc, upd_taken, upd_target, upd_is_jump, flush,
    input  hit, pred_taken, pred_target
  );

  modport slave (
    input  fetch_pc, upd_en, upd_pc, upd_taken, upd_target, upd_is_jump, flush,
    output hit, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters and
// zero-latency lookup. Define BTB_STATS_EN to add lookup/hit/mispredict counters.
module branch_target_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  branch_target_buffer_if.slave  bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]            lookup_cnt,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  jump_q, jump_d;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [ADDR_W-1:0] target_d [DEPTH];
  logic [1:0]        ctr_q [DEPTH];
  logic [1:0]        ctr_d [DEPTH];

  logic [IDX_W-1:0]  f_idx, u_idx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  logic              f_hit, f_taken, u_hit;
  logic [1:0]        unused_upd_lsb;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_upd_lsb = bus.upd_pc[1:0];

  // Lookup reads only registered state, so a same-cycle update is seen next cycle
  assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign bus.hit         = f_hit;
  assign bus.pred_taken  = f_taken;
  assign bus.pred_target = f_taken ? target_q[f_idx] : bus.fetch_pc + ADDR_W'(4);

  always_comb begin
    valid_d  = valid_q;
    jump_d   = jump_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.flush) begin
      valid_d = '0;
    end else if (bus.upd_en) begin
      if (u_hit) begin
        if (bus.upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
          target_d[u_idx] = bus.upd_target;
          jump_d[u_idx]   = bus.upd_is_jump;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        // Allocation only on taken outcomes; new conditional entries start weakly taken
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bus.upd_target;
        jump_d[u_idx]   = bus.upd_is_jump;
        ctr_d[u_idx]    = bus.upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= '0;
      jump_q   <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      jump_q   <= jump_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic        u_pred, mispred;

  // Mispredict compares the resolved outcome with what the table held before this edge
  assign u_pred  = u_hit && (jump_q[u_idx] || ctr_q[u_idx][1]);
  assign mispred = (u_pred != bus.upd_taken) ||
                   (bus.upd_taken && (target_q[u_idx] != bus.upd_target));

  always_comb begin
    lookup_cnt_d  = lookup_cnt_q;
    hit_cnt_d     = hit_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (!bus.flush) begin
      lookup_cnt_d = lookup_cnt_q + 32'd1;
      if (f_hit) hit_cnt_d = hit_cnt_q + 32'd1;
      if (bus.upd_en && mispred) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lookup_cnt_q  <= '0;
      hit_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      lookup_cnt_q  <= lookup_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign lookup_cnt  = lookup_cnt_q;
  assign hit_cnt     = hit_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized checks of branch_target_buffer against a
// table-level reference model held in the bench.
module tb_branch_target_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic CLK = 1'b0;
  logic nRST;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 CLK = ~CLK;

  branch_target_buffer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef BTB_STATS_EN
  logic [31:0] lookup_cnt, hit_cnt, mispred_cnt;
`endif

  branch_target_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
`ifdef BTB_STATS_EN
    ,
    .lookup_cnt(lookup_cnt),
    .hit_cnt(hit_cnt),
    .mispred_cnt(mispred_cnt)
`endif
  );

  // Reference model: one record per entry, counters kept as plain integers 0..3
  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  logic [31:0] m_target[DEPTH];
  bit          m_jump  [DEPTH];
  int          m_ctr   [DEPTH];
  logic [31:0] m_lookups, m_hits, m_mispreds;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc / (DEPTH * 4));
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_jump[idx_of(pc)] || m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_pred(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_jump[i] = 0; m_ctr[i] = 0;
    end
    m_lookups = '0; m_hits = '0; m_mispreds = '0;
  endtask

  task automatic model_update(input logic [31:0] pc, input bit taken,
                              input logic [31:0] tgt, input bit jmp);
    int i;
    i = idx_of(pc);
    if (m_hit(pc)) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = tgt;
        m_jump[i] = jmp;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt; m_jump[i] = jmp;
      m_ctr[i] = jmp ? 3 : 2;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
    end
  endtask

  task automatic drive(input logic [31:0] fpc, input bit en, input logic [31:0] upc,
                       input bit taken, input logic [31:0] tgt, input bit jmp, input bit fl);
    bus.fetch_pc    = fpc;
    bus.upd_en      = en;
    bus.upd_pc      = upc;
    bus.upd_taken   = taken;
    bus.upd_target  = tgt;
    bus.upd_is_jump = jmp;
    bus.flush       = fl;
  endtask

  // Compare lookup outputs with the model, advance the model, then clock one edge
  task automatic finish_cycle();
    logic [31:0] fpc, upc;
    fpc = bus.fetch_pc;
    upc = bus.upd_pc;
    check_output("hit", {31'b0, bus.hit}, {31'b0, m_hit(fpc)});
    check_output("pred_taken", {31'b0, bus.pred_taken}, {31'b0, m_pred(fpc)});
    check_output("pred_target", bus.pred_target, m_next(fpc));
    if (!bus.flush) begin
      m_lookups = m_lookups + 32'd1;
      if (m_hit(fpc)) m_hits = m_hits + 32'd1;
      if (bus.upd_en) begin
        if ((m_pred(upc) != bus.upd_taken) ||
            (bus.upd_taken && m_next(upc) != bus.upd_target))
          m_mispreds = m_mispreds + 32'd1;
        model_update(upc, bus.upd_taken, bus.upd_target, bus.upd_is_jump);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic apply_stimulus(input logic [31:0] fpc, input bit en, input logic [31:0] upc,
                                input bit taken, input logic [31:0] tgt, input bit jmp,
                                input bit fl);
    drive(fpc, en, upc, taken, tgt, jmp, fl);
    #1;
    finish_cycle();
  endtask

  task automatic update(input logic [31:0] upc, input bit taken, input logic [31:0] tgt,
                        input bit jmp);
    apply_stimulus(32'h0000_1000, 1'b1, upc, taken, tgt, jmp, 1'b0);
  endtask

  // Directed check against values worked out by hand, without a clock edge
  task automatic expect_lookup(input string name, input logic [31:0] fpc, input bit h,
                               input bit pt, input logic [31:0] tgt);
    drive(fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output({name, ".hit"}, {31'b0, bus.hit}, {31'b0, h});
    check_output({name, ".taken"}, {31'b0, bus.pred_taken}, {31'b0, pt});
    check_output({name, ".target"}, bus.pred_target, tgt);
  endtask

  task automatic check_stats(input string name);
`ifdef BTB_STATS_EN
    check_output({name, ".lookup_cnt"}, lookup_cnt, m_lookups);
    check_output({name, ".hit_cnt"}, hit_cnt, m_hits);
    check_output({name, ".mispred_cnt"}, mispred_cnt, m_mispreds);
`else
    total_cnt = total_cnt + 0;
    if (name.len() == 0) $display("[TB] stats disabled");
`endif
  endtask

  function automatic logic [31:0] rand_pc();
    logic [25:0] tags [4];
    tags[0] = 26'd0; tags[1] = 26'd1; tags[2] = 26'd2; tags[3] = 26'h3FF_FFFF;
    if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
    return {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    nRST = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    $display("[TB] reset state");
    expect_lookup("rst40", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    expect_lookup("rstwrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    $display("[TB] allocation and counter training");
    update(32'h40, 1'b1, 32'h100, 1'b0);
    expect_lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    update(32'h40, 1'b0, 32'h0, 1'b0);
    update(32'h40, 1'b0, 32'h0, 1'b0);
    expect_lookup("ctr00", 32'h40, 1'b1, 1'b0, 32'h44);
    update(32'h40, 1'b0, 32'h0, 1'b0);
    expect_lookup("ctr00sat", 32'h40, 1'b1, 1'b0, 32'h44);
    repeat (4) update(32'h40, 1'b1, 32'h100, 1'b0);
    expect_lookup("ctr11", 32'h40, 1'b1, 1'b1, 32'h100);
    repeat (2) update(32'h40, 1'b0, 32'h0, 1'b0);
    expect_lookup("ctr11sat", 32'h40, 1'b1, 1'b0, 32'h44);

    $display("[TB] jump entries");
    update(32'h80, 1'b1, 32'h200, 1'b1);
    repeat (10) update(32'h80, 1'b0, 32'h0, 1'b0);
    expect_lookup("jumpsticky", 32'h80, 1'b1, 1'b1, 32'h200);
    update(32'h80, 1'b1, 32'h300, 1'b1);
    expect_lookup("jr", 32'h80, 1'b1, 1'b1, 32'h300);

    $display("[TB] aliasing");
    update(32'h40, 1'b1, 32'h100, 1'b0);
    update(32'h440, 1'b1, 32'h500, 1'b0);
    expect_lookup("alias40", 32'h40, 1'b0, 1'b0, 32'h44);
    expect_lookup("alias440", 32'h440, 1'b1, 1'b1, 32'h500);
    update(32'h840, 1'b0, 32'h900, 1'b0);
    expect_lookup("noalloc840", 32'h840, 1'b0, 1'b0, 32'h844);
    expect_lookup("keep440", 32'h440, 1'b1, 1'b1, 32'h500);

    $display("[TB] same-cycle lookup and update");
    drive(32'h440, 1'b1, 32'h440, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("samecyc.old", bus.pred_target, 32'h500);
    finish_cycle();
    expect_lookup("samecyc.new", 32'h440, 1'b1, 1'b0, 32'h444);

    $display("[TB] flush");
    apply_stimulus(32'h440, 1'b1, 32'hC0, 1'b1, 32'h600, 1'b0, 1'b1);
    expect_lookup("flush440", 32'h440, 1'b0, 1'b0, 32'h444);
    expect_lookup("flushC0", 32'hC0, 1'b0, 1'b0, 32'hC4);
    update(32'h80, 1'b1, 32'h200, 1'b1);
    expect_lookup("realloc", 32'h80, 1'b1, 1'b1, 32'h200);
    check_stats("directed");

    $display("[TB] asynchronous reset mid-update");
    drive(32'h80, 1'b1, 32'h100, 1'b1, 32'h700, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    check_output("arst.hit", {31'b0, bus.hit}, 32'd0);
    check_output("arst.target", bus.pred_target, 32'h84);
    model_reset();
    check_stats("arst");
    @(posedge CLK);
    @(negedge CLK);
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    nRST = 1'b1;
    expect_lookup("arst.dropped", 32'h100, 1'b0, 1'b0, 32'h104);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
                     1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
    end
    check_stats("random");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised, stateful successor to the combinational jump-address path.
- Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
- Fetch stage looks up the current PC and gets a predicted next PC in the same cycle.
- Execute/memory stage writes back resolved branch and jump outcomes.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥2; IDX_W = log2(DEPTH).
- ADDR_W, 32, PC and target width in bits; word-aligned, bits [1:0] ignored.

Ports:
- CLK  in  1  rising-edge clock.
- nRST  in  1  asynchronous active-low reset.
- fetch_pc  in  ADDR_W  PC being fetched.
- hit  out  1  valid entry with matching tag at fetch_pc.
- pred_taken  out  1  predict redirect.
- pred_target  out  ADDR_W  predicted next PC.
- upd_en  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  ADDR_W  resolved target address.
- upd_is_jump  in  1  unconditional (J/JAL/JR).
- flush  in  1  invalidate every entry next edge.

Behaviour:
- Clock and reset: one clock CLK; nRST asynchronous, active-low.
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- Entry fields: valid, tag, target, jump bit, ctr[1:0].
- Lookup is combinational, zero latency.
  - hit = valid & tag match.
  - pred_taken = hit & (jump | ctr[1]).
  - pred_target = pred_taken ? entry.target : fetch_pc+4, modulo 2^ADDR_W (wraps 0xFFFFFFFC -> 0x00000000).
- Reset (nRST=0, async): all valid=0, ctr=00, target=0, jump=0.
  - Outputs then: hit=0, pred_taken=0, pred_target=fetch_pc+4.
- Update on a CLK edge when upd_en=1.
  - Tag hit, taken: ctr saturating increment (max 11); target <= upd_target; jump <= upd_is_jump.
  - Tag hit, not taken: ctr saturating decrement (min 00); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate/replace; valid=1, tag, target written, jump=upd_is_jump.
    - ctr=11 if jump, else 10 (weakly taken).
  - Miss, not taken: no change; no allocation on not-taken.
- Jump entries are always predicted taken regardless of ctr.
  - Updates on a jump entry still write target, so JR retargeting is followed.
- Same-cycle lookup and update to the same index: lookup returns pre-edge contents; no write-to-read bypass.
- flush=1 at an edge clears all valid bits and ignores upd_en that cycle; flush has priority.
- Reset mid-update: the update is discarded and the table is cleared immediately.
- No stall input: the caller gates upd_en.
- fetch_pc is sampled only combinationally; the block holds no fetch-side state.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds outputs lookup_cnt (32), hit_cnt (32), mispred_cnt (32).
  - lookup_cnt increments every cycle nRST=1 & flush=0.
  - hit_cnt increments when hit=1 in such a cycle.
  - mispred_cnt increments on upd_en when the stored prediction at upd_pc (recomputed from pre-edge table state) disagrees with upd_taken, or when taken and the stored target ≠ upd_target.
  - All three clear on nRST; they are not cleared by flush; they wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then fetch_pc=0x00000040 -> hit=0, pred_taken=0, pred_target=0x00000044; fetch_pc=0xFFFFFFFC -> pred_target=0x00000000.
- upd_en, upd_pc=0x40, taken, target=0x100, not jump -> next cycle fetch 0x40: hit=1, pred_taken=1 (ctr=10), pred_target=0x100.
- Two not-taken updates at 0x40 -> ctr 10->01->00; fetch 0x40: hit=1, pred_taken=0, target 0x44. Further not-taken keeps ctr=00. Three taken updates -> ctr 11, saturates.
- Jump at 0x80 -> 0x200 allocated, then ten not-taken updates -> still pred_taken=1. JR update to target 0x300 -> pred_target=0x300.
- Aliasing (DEPTH=16): entry for 0x40 taken; update taken 0x440 -> 0x500 replaces it -> fetch 0x40 hit=0; fetch 0x440 -> 0x500. Update not-taken at 0x840 -> no allocation.
- Same-cycle: update 0x40 while fetching 0x40 -> old result this cycle, new next cycle. flush with upd_en -> all misses, update dropped. nRST pulse mid-sequence -> outputs at reset values immediately (async). With BTB_STATS_EN: counter values match a scoreboard.
